// File: rtl/regbank_bus_reader.sv
// regbank_bus_reader: reads registers on a shared tri-state bus via one-hot-low chip selects
module regbank_bus_reader #(
    parameter int NrOfBits = 32,
    parameter int NrOfRegs = 8,
    parameter int AddrBits = 3
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Tick,
    input  logic                req_valid,
    input  logic [AddrBits-1:0] req_addr,
    input  logic [AddrBits:0]   req_len,
    output logic                req_ready,
    output logic [NrOfRegs-1:0] cs,
    input  logic [NrOfBits-1:0] Bus,
    output logic                rsp_valid,
    output logic [NrOfBits-1:0] rsp_data,
    output logic                rsp_last,
    output logic                rsp_err,
    input  logic                rsp_ready
);
    typedef enum logic [1:0] {IDLE, SELECT, CAPTURE, RESPOND} state_t;
    localparam logic [AddrBits:0] ONE = 1;
    state_t state, state_n;
    logic [AddrBits-1:0] addr, addr_n;
    logic [AddrBits:0] cnt, cnt_n;
    logic [NrOfRegs-1:0] cs_n;
    logic [NrOfBits-1:0] rsp_data_n;
    logic rsp_valid_n, rsp_last_n, rsp_err_n, oob;

    // Out-of-range addresses decode to no select at all, so the bus stays floating
    function automatic logic [NrOfRegs-1:0] decode(input logic [AddrBits-1:0] a);
        logic [NrOfRegs-1:0] d;
        for (int i = 0; i < NrOfRegs; i++) d[i] = int'(a) != i;
        return d;
    endfunction

    assign req_ready = state == IDLE;
    assign oob = int'(addr) >= NrOfRegs;

    // Next-state and next-register values; cs is loaded one edge ahead so it is low for SELECT and CAPTURE
    always_comb begin
        state_n = state;
        addr_n = addr;
        cnt_n = cnt;
        cs_n = cs;
        rsp_valid_n = rsp_valid;
        rsp_data_n = rsp_data;
        rsp_last_n = rsp_last;
        rsp_err_n = rsp_err;
        case (state)
            IDLE: if (req_valid) begin
                state_n = SELECT;
                addr_n = req_addr;
                cnt_n = (req_len == '0) ? ONE : req_len;
                cs_n = decode(req_addr);
            end
            SELECT: state_n = CAPTURE;
            CAPTURE: begin
                state_n = RESPOND;
                cs_n = '1;
                rsp_valid_n = 1'b1;
                rsp_data_n = oob ? '0 : Bus;
                rsp_err_n = oob;
                rsp_last_n = cnt == ONE;
            end
            RESPOND: if (rsp_ready) begin
                cnt_n = cnt - ONE;
                addr_n = addr + 1'b1;
                rsp_valid_n = 1'b0;
                rsp_last_n = 1'b0;
                rsp_err_n = 1'b0;
                state_n = (cnt == ONE) ? IDLE : SELECT;
                cs_n = (cnt == ONE) ? '1 : decode(addr_n);
            end
            default: state_n = IDLE;
        endcase
    end

    // State register, advancing only on Tick edges; reset releases the bus immediately
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
            addr <= '0;
            cnt <= '0;
            cs <= '1;
            rsp_valid <= 1'b0;
            rsp_data <= '0;
            rsp_last <= 1'b0;
            rsp_err <= 1'b0;
        end else if (Tick) begin
            state <= state_n;
            addr <= addr_n;
            cnt <= cnt_n;
            cs <= cs_n;
            rsp_valid <= rsp_valid_n;
            rsp_data <= rsp_data_n;
            rsp_last <= rsp_last_n;
            rsp_err <= rsp_err_n;
        end
    end
endmodule

// File: tb/tb_regbank_bus_reader.sv
// tb_regbank_bus_reader: directed vectors and corner sequences for regbank_bus_reader
module tb_regbank_bus_reader;
    localparam logic [31:0] FLOAT = 32'hF1F1_F1F1;
    logic Clock = 0, Reset = 0, Tick = 0, req_valid = 0, rsp_ready = 0;
    logic [2:0] req_addr = '0;
    logic [3:0] req_len = '0;
    logic [31:0] regs [8];
    logic [31:0] bus8, bus6, rsp_data8, rsp_data6;
    logic [7:0] cs8;
    logic [5:0] cs6;
    logic req_ready8, rsp_valid8, rsp_last8, rsp_err8;
    logic req_ready6, rsp_valid6, rsp_last6, rsp_err6;
    int checks = 0, errors = 0, bad_cs = 0, bad_tick = 0;
    logic gate_chk = 0, tick_e = 0;
    logic [43:0] prev_sig = '0;
    logic [7:0] prev_cs8 = '1;
    logic [5:0] prev_cs6 = '1;

    typedef struct {
        logic [2:0] addr;
        logic [3:0] len;
        int n;
        logic [3:0][31:0] d;
    } vec_t;
    vec_t vecs [5];

    logic [7:0] oob_cs8 [10] = '{8'hEF, 8'hEF, 8'hFF, 8'hDF, 8'hDF, 8'hFF, 8'hBF, 8'hBF, 8'hFF, 8'hFF};
    logic [5:0] oob_cs6 [10] = '{6'h2F, 6'h2F, 6'h3F, 6'h1F, 6'h1F, 6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F};
    logic oob_v [10] = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 0};

    regbank_bus_reader #(.NrOfBits(32), .NrOfRegs(8), .AddrBits(3)) u_dut8 (
        .Clock(Clock), .Reset(Reset), .Tick(Tick), .req_valid(req_valid), .req_addr(req_addr),
        .req_len(req_len), .req_ready(req_ready8), .cs(cs8), .Bus(bus8), .rsp_valid(rsp_valid8),
        .rsp_data(rsp_data8), .rsp_last(rsp_last8), .rsp_err(rsp_err8), .rsp_ready(rsp_ready)
    );
    regbank_bus_reader #(.NrOfBits(32), .NrOfRegs(6), .AddrBits(3)) u_dut6 (
        .Clock(Clock), .Reset(Reset), .Tick(Tick), .req_valid(req_valid), .req_addr(req_addr),
        .req_len(req_len), .req_ready(req_ready6), .cs(cs6), .Bus(bus6), .rsp_valid(rsp_valid6),
        .rsp_data(rsp_data6), .rsp_last(rsp_last6), .rsp_err(rsp_err6), .rsp_ready(rsp_ready)
    );

    always #5 Clock = ~Clock;

    always_comb begin
        bus8 = FLOAT;
        for (int i = 0; i < 8; i++) if (!cs8[i]) bus8 = regs[i];
    end
    always_comb begin
        bus6 = FLOAT;
        for (int i = 0; i < 6; i++) if (!cs6[i]) bus6 = regs[i];
    end

    always @(posedge Clock) tick_e <= Tick;

    always @(negedge Clock) begin
        if ($countones(~cs8) > 1 || $countones(~cs6) > 1) bad_cs++;
        if (cs8 != '1 && prev_cs8 != '1 && cs8 != prev_cs8) bad_cs++;
        if (cs6 != '1 && prev_cs6 != '1 && cs6 != prev_cs6) bad_cs++;
        if (gate_chk && !tick_e && {cs8, rsp_valid8, rsp_last8, rsp_err8, req_ready8, rsp_data8} != prev_sig) bad_tick++;
        prev_cs8 <= cs8;
        prev_cs6 <= cs6;
        prev_sig <= {cs8, rsp_valid8, rsp_last8, rsp_err8, req_ready8, rsp_data8};
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] a, input logic [3:0] l);
        Tick = 1;
        req_valid = 1;
        req_addr = a;
        req_len = l;
        @(negedge Clock);
        req_valid = 0;
    endtask

    task automatic collect(input string nm, input int n, input logic [3:0][31:0] d, input int tdiv);
        int k = 0;
        int cyc = 1;
        rsp_ready = 1;
        while (k < n && cyc < 200) begin
            Tick = (cyc % tdiv) == 0;
            cyc++;
            if (rsp_valid8 && Tick) begin
                chk({nm, "_data"}, rsp_data8, d[k]);
                chk({nm, "_last"}, rsp_last8, k == n - 1);
                chk({nm, "_err"}, rsp_err8, 0);
                k++;
            end
            @(negedge Clock);
        end
        chk({nm, "_beats"}, k, n);
        chk({nm, "_idle"}, {req_ready8, rsp_valid8, cs8}, {2'b10, 8'hFF});
        Tick = 1;
    endtask

    task automatic single_read;
        regs[5] = 32'hDEAD_BEEF;
        rsp_ready = 0;
        issue(3'd5, 4'd1);
        chk("t1_cs_sel", cs8, 8'hDF);
        chk("t1_busy", req_ready8, 0);
        @(negedge Clock);
        chk("t1_cs_cap", cs8, 8'hDF);
        chk("t1_valid_early", rsp_valid8, 0);
        @(negedge Clock);
        chk("t1_cs_rsp", cs8, 8'hFF);
        chk("t1_rsp", {rsp_valid8, rsp_last8, rsp_err8, rsp_data8}, {3'b110, 32'hDEAD_BEEF});
        rsp_ready = 1;
        @(negedge Clock);
        chk("t1_done", {rsp_valid8, req_ready8}, 2'b01);
        regs[5] = 32'd5;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) regs[i] = i;
        vecs[0] = '{3'd6, 4'd4, 4, {32'd1, 32'd0, 32'd7, 32'd6}};
        vecs[1] = '{3'd3, 4'd0, 1, {32'd0, 32'd0, 32'd0, 32'd3}};
        vecs[2] = '{3'd2, 4'd1, 1, {32'd0, 32'd0, 32'd0, 32'd2}};
        vecs[3] = '{3'd7, 4'd2, 2, {32'd0, 32'd0, 32'd0, 32'd7}};
        vecs[4] = '{3'd0, 4'd3, 3, {32'd0, 32'd2, 32'd1, 32'd0}};
        @(negedge Clock);
        chk("rst_state", {req_ready8, rsp_valid8, rsp_last8, rsp_err8, cs8, rsp_data8}, {4'b1000, 8'hFF, 32'h0});
        chk("rst_cs6", cs6, 6'h3F);
        Reset = 1;
        Tick = 1;
        @(negedge Clock);
        single_read();
        for (int v = 0; v < 5; v++) begin
            issue(vecs[v].addr, vecs[v].len);
            collect($sformatf("vec%0d", v), vecs[v].n, vecs[v].d, 1);
        end
        rsp_ready = 0;
        issue(3'd1, 4'd2);
        @(negedge Clock);
        @(negedge Clock);
        chk("bp_first", {rsp_valid8, rsp_last8, rsp_data8}, {2'b10, 32'd1});
        for (int c = 0; c < 5; c++) begin
            @(negedge Clock);
            chk($sformatf("bp_hold%0d", c), {rsp_valid8, rsp_last8, cs8, rsp_data8}, {2'b10, 8'hFF, 32'd1});
        end
        rsp_ready = 1;
        @(negedge Clock);
        chk("bp_sel2", {rsp_valid8, cs8}, {1'b0, 8'hFB});
        @(negedge Clock);
        @(negedge Clock);
        chk("bp_second", {rsp_valid8, rsp_last8, rsp_data8}, {2'b11, 32'd2});
        @(negedge Clock);
        chk("bp_idle", req_ready8, 1);
        issue(3'd4, 4'd3);
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("oob_cs6_%0d", c), cs6, oob_cs6[c]);
            chk($sformatf("oob_cs8_%0d", c), cs8, oob_cs8[c]);
            chk($sformatf("oob_v_%0d", c), {rsp_valid6, rsp_valid8}, {2{oob_v[c]}});
            if (oob_v[c]) begin
                chk($sformatf("oob_d6_%0d", c), {rsp_err6, rsp_last6, rsp_data6}, (c == 8) ? {2'b11, 32'd0} : {2'b00, 32'(4 + c / 3)});
                chk($sformatf("oob_d8_%0d", c), {rsp_err8, rsp_last8, rsp_data8}, {1'b0, c == 8, 32'(4 + c / 3)});
            end
            @(negedge Clock);
        end
        gate_chk = 1;
        issue(3'd6, 4'd4);
        collect("gate", 4, {32'd1, 32'd0, 32'd7, 32'd6}, 3);
        gate_chk = 0;
        @(negedge Clock);
        issue(3'd2, 4'd3);
        @(negedge Clock);
        @(negedge Clock);
        @(negedge Clock);
        @(negedge Clock);
        chk("mr_pre", {rsp_valid8, cs8}, {1'b0, 8'hF7});
        Reset = 0;
        #1;
        chk("mr_async", {rsp_valid8, req_ready8, cs8, cs6}, {2'b01, 8'hFF, 6'h3F});
        @(negedge Clock);
        chk("mr_hold", {rsp_valid8, rsp_last8, rsp_err8, req_ready8, cs8}, {4'b0001, 8'hFF});
        Reset = 1;
        @(negedge Clock);
        single_read();
        chk("cs_onehot", bad_cs, 0);
        chk("tick_gate", bad_tick, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end
endmodule

// File: doc/regbank_bus_reader.md
Name: regbank_bus_reader

Overview:
- Read-side master for banks of tri-state output registers that share one data bus.
- Accepts a read request (single register or burst), drives the active-low chip-select of the target register, waits one settle cycle, captures the bus and returns data on a valid/ready response channel.
- Sits between the datapath/debug readback logic and the register banks in the memory subsystem.
- Guarantees that at most one register drives the shared bus at any time.

Parameters:
- NrOfBits, 32, width of the shared data bus and response data.
- NrOfRegs, 8, number of registers on the bus; must be 2..256.
- AddrBits, 3, request address width; must be ≥ clog2(NrOfRegs).

Ports:
- Clock  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Tick  input  1  global clock-enable; state and outputs update only on edges where Tick=1.
- req_valid  input  1  read request present.
- req_addr  input  AddrBits  first register index.
- req_len  input  AddrBits+1  beat count; 0 is treated as 1.
- req_ready  output  1  high only in IDLE.
- cs  output  NrOfRegs  per-register output-disable; bit i=0 means register i drives Bus; all ones means the bus floats.
- Bus  input  NrOfBits  shared tri-state data bus.
- rsp_valid  output  1  response beat valid.
- rsp_data  output  NrOfBits  captured bus value.
- rsp_last  output  1  final beat of the request.
- rsp_err  output  1  beat address ≥ NrOfRegs; rsp_data=0.
- rsp_ready  input  1  consumer accepts the beat.

Behaviour:
- Reset low, asynchronous:
  - state=IDLE, cs all ones, req_ready=1.
  - rsp_valid=0, rsp_data=0, rsp_last=0, rsp_err=0, counters=0.
- Tick=0: hold all registers; no handshake completes on that edge.
- FSM states: IDLE → SELECT → CAPTURE → RESPOND → (SELECT | IDLE).
- IDLE:
  - req_ready=1.
  - On req_valid=1 at a Tick edge, latch addr and len (max(len,1)), go to SELECT.
- SELECT:
  - If addr < NrOfRegs: cs[addr]=0, all other bits 1 (settle cycle).
  - If addr ≥ NrOfRegs: cs stays all ones and the error flag is set.
  - Always advances to CAPTURE.
- CAPTURE:
  - cs unchanged.
  - On the edge, rsp_data ← Bus, or ← 0 with rsp_err=1 if out of range.
  - Go to RESPOND.
- RESPOND:
  - cs all ones; rsp_valid=1.
  - rsp_last=1 when the remaining count is 1.
  - rsp_data, rsp_last and rsp_err are stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_ready=1 at a Tick edge:
    - Decrement the count and increment addr, wrapping mod 2^AddrBits.
    - If the count reaches 0, go to IDLE and clear rsp_valid, rsp_last and rsp_err.
    - Otherwise go to SELECT.
- Latency with Tick=1: request accept at edge N; cs low during cycles N+1..N+2; rsp_valid high from N+3. Each further burst beat adds 3 cycles after its acceptance.
- Bus safety:
  - cs has at most one zero bit in every cycle.
  - cs is all ones in IDLE and RESPOND, so there is always at least one all-ones cycle between two different selects.
- Out-of-range addresses in a burst produce err beats; in-range beats of the same burst read normally.
- Reset asserted mid-burst: immediate return to the reset state, cs released asynchronously, no partial beat is presented.
- cs is driven from a register, not decoded combinationally from state.

Test Plan:
- Reset then single read: register 5 drives 0xDEADBEEF, req addr=5 len=1 → cs=8'b1101_1111 for 2 cycles, then rsp_valid with data 0xDEADBEEF, last=1, err=0, and req_ready returns high.
- Burst wrap: NrOfRegs=8, addr=6 len=4, registers drive their own index → beats 6,7,0,1 with last only on beat 4, and cs always one-hot-low or all ones.
- Backpressure: rsp_ready=0 for 5 cycles on beat 1 of len=2 → data/last held stable and cs all ones throughout; beat 2 starts only after acceptance.
- Out of range: NrOfRegs=6, AddrBits=3, addr=4 len=3 → beats 4,5 valid, beat 6 has err=1 and data=0, with no cs bit low during that beat.
- Tick gating: Tick pulsing 1 every 3rd cycle → same beat sequence as with Tick=1, with all transitions only on Tick edges.
- Mid-operation reset: Reset low during CAPTURE of beat 2 → cs all ones and rsp_valid=0 immediately; after release the next request len=1 behaves as in test 1.
